// File: rtl/pc_addr_unit_pkg.sv
// Shared CPU constants: default datapath widths and the Lscntl address-select encoding
// used by both the control FSM and the PC/address unit.
package pc_addr_unit_pkg;

    localparam int unsigned CPU_DW = 16;
    localparam int unsigned CPU_AW = 16;

    // Lscntl encoding
    localparam logic ADDR_PC   = 1'b1;
    localparam logic ADDR_DATA = 1'b0;

endpackage

// File: rtl/pc_addr_unit_if.sv
// Synchronous RAM port as seen from the CPU.
// The master drives address and write enable; the slave (RAM) returns read data.
interface pc_addr_unit_if
    import pc_addr_unit_pkg::*;
#(
    parameter int unsigned DW = CPU_DW,
    parameter int unsigned AW = CPU_AW
);

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/pc_addr_unit.sv
// Program counter, jump/link handling, RAM address select, instruction register and
// writeback bus mux for the small CPU datapath.
module pc_addr_unit
    import pc_addr_unit_pkg::*;
#(
    parameter int unsigned   DW       = CPU_DW,
    parameter int unsigned   AW       = CPU_AW,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCe,
    input  logic          Lscntl,
    input  logic          WE,
    input  logic          i_en,
    input  logic          npc_ctrl,
    input  logic          mem_pc_ctrl,
    input  logic          s_mem_to_bus,
    input  logic [AW-1:0] reg_addr,
    pc_addr_unit_if.master mem,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] bus_out
);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] link_q, link_d;
    logic [AW-1:0] data_addr_q, data_addr_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          jmp_hold_q, jmp_hold_d;
    logic [AW-1:0] pc_inc;

    assign pc_inc = pc_q + AW'(1);

    // A jump is issued as a PCe+npc_ctrl strobe followed by one trailing plain PCe strobe;
    // jmp_hold swallows that trailing strobe so the target is not skipped.
    always_comb begin
        pc_d        = pc_q;
        link_d      = link_q;
        jmp_hold_d  = jmp_hold_q;
        data_addr_d = data_addr_q;
        ir_d        = ir_q;

        if (PCe) begin
            if (npc_ctrl) begin
                pc_d       = reg_addr;
                link_d     = pc_inc;
                jmp_hold_d = 1'b1;
            end else if (jmp_hold_q) begin
                jmp_hold_d = 1'b0;
            end else begin
                pc_d = pc_inc;
            end
        end

        if (Lscntl == ADDR_DATA) begin
            data_addr_d = reg_addr;
        end

        if (i_en) begin
            ir_d = mem.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            link_q      <= '0;
            jmp_hold_q  <= 1'b0;
            data_addr_q <= '0;
            ir_q        <= '0;
        end else begin
            pc_q        <= pc_d;
            link_q      <= link_d;
            jmp_hold_q  <= jmp_hold_d;
            data_addr_q <= data_addr_d;
            ir_q        <= ir_d;
        end
    end

    // Writes hold the address latched while Lscntl was low, so a store spanning
    // the Lscntl 0->1 transition keeps pointing at the same word.
    always_comb begin
        if (Lscntl == ADDR_DATA) begin
            mem.mem_addr = reg_addr;
        end else if (WE) begin
            mem.mem_addr = data_addr_q;
        end else begin
            mem.mem_addr = pc_q;
        end
    end

    assign mem.mem_we = WE;

    always_comb begin
        if (mem_pc_ctrl) begin
            bus_out = DW'(link_q);
        end else if (s_mem_to_bus) begin
            bus_out = mem.mem_rdata;
        end else begin
            bus_out = '0;
        end
    end

    assign ir = ir_q;
    assign pc = pc_q;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Directed bench for pc_addr_unit: reset, PC increment/wrap, jump sequence with link,
// store address hold, IR load/hold, bus mux priority and reset in the middle of a jump.
module tb_pc_addr_unit;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          PCe, Lscntl, WE, i_en, npc_ctrl, mem_pc_ctrl, s_mem_to_bus;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] ir;
    logic [AW-1:0] pc;
    logic [DW-1:0] bus_out;

    int vectors = 0;
    int miscompares = 0;

    pc_addr_unit_if #(.DW(DW), .AW(AW)) mem_bus ();

    pc_addr_unit #(
        .DW      (DW),
        .AW      (AW),
        .RESET_PC(16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCe         (PCe),
        .Lscntl      (Lscntl),
        .WE          (WE),
        .i_en        (i_en),
        .npc_ctrl    (npc_ctrl),
        .mem_pc_ctrl (mem_pc_ctrl),
        .s_mem_to_bus(s_mem_to_bus),
        .reg_addr    (reg_addr),
        .mem         (mem_bus),
        .ir          (ir),
        .pc          (pc),
        .bus_out     (bus_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset        = 1'b1;
        PCe          = 1'b0;
        Lscntl       = 1'b1;
        WE           = 1'b0;
        i_en         = 1'b0;
        npc_ctrl     = 1'b0;
        mem_pc_ctrl  = 1'b0;
        s_mem_to_bus = 1'b0;
        reg_addr     = 16'h0000;
        mem_bus.mem_rdata = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_ir", 32'(ir), 32'h0000);
        mem_pc_ctrl = 1'b1;
        #1;
        check("rst_link", 32'(bus_out), 32'h0000);
        mem_pc_ctrl = 1'b0;
        #1;
        check("idle_bus", 32'(bus_out), 32'h0000);
        check("fetch_addr0", 32'(mem_bus.mem_addr), 32'h0000);

        // Sequential fetch
        PCe = 1'b1;
        tick();
        check("inc_pc1", 32'(pc), 32'h0001);
        check("fetch_addr1", 32'(mem_bus.mem_addr), 32'h0001);
        tick();
        check("inc_pc2", 32'(pc), 32'h0002);
        tick();
        check("inc_pc3", 32'(pc), 32'h0003);
        check("fetch_addr3", 32'(mem_bus.mem_addr), 32'h0003);
        tick();
        tick();
        check("inc_pc5", 32'(pc), 32'h0005);

        // Jump 0x0005 -> 0x0040
        reg_addr = 16'h0040;
        npc_ctrl = 1'b1;
        tick();
        check("jmp_pc", 32'(pc), 32'h0040);
        PCe = 1'b0;
        tick();
        check("jmp_npc_only", 32'(pc), 32'h0040);
        PCe      = 1'b1;
        npc_ctrl = 1'b0;
        tick();
        check("jmp_absorb", 32'(pc), 32'h0040);
        PCe         = 1'b0;
        mem_pc_ctrl = 1'b1;
        #1;
        check("jmp_link", 32'(bus_out), 32'h0006);
        mem_pc_ctrl = 1'b0;
        PCe         = 1'b1;
        tick();
        check("post_jmp_inc", 32'(pc), 32'h0041);
        PCe = 1'b0;

        // Store address held across Lscntl 0->1
        Lscntl   = 1'b0;
        WE       = 1'b1;
        reg_addr = 16'h0100;
        #1;
        check("st_addr_a", 32'(mem_bus.mem_addr), 32'h0100);
        check("st_we_a", 32'(mem_bus.mem_we), 32'h1);
        tick();
        Lscntl   = 1'b1;
        reg_addr = 16'h0200;
        #1;
        check("st_addr_b", 32'(mem_bus.mem_addr), 32'h0100);
        check("st_we_b", 32'(mem_bus.mem_we), 32'h1);
        WE = 1'b0;
        #1;
        check("st_release", 32'(mem_bus.mem_addr), 32'h0041);
        check("st_we_off", 32'(mem_bus.mem_we), 32'h0);

        // PC wrap: jump to 0xFFFF, absorb, then increment
        reg_addr = 16'hFFFF;
        PCe      = 1'b1;
        npc_ctrl = 1'b1;
        tick();
        check("wrap_jmp", 32'(pc), 32'hFFFF);
        npc_ctrl = 1'b0;
        tick();
        check("wrap_absorb", 32'(pc), 32'hFFFF);
        tick();
        check("wrap_pc", 32'(pc), 32'h0000);
        PCe = 1'b0;

        // IR load and hold, bus mux
        mem_bus.mem_rdata = 16'hA5A5;
        i_en = 1'b1;
        tick();
        check("ir_load", 32'(ir), 32'hA5A5);
        i_en = 1'b0;
        mem_bus.mem_rdata = 16'h1234;
        tick();
        check("ir_hold", 32'(ir), 32'hA5A5);
        s_mem_to_bus = 1'b1;
        #1;
        check("bus_rdata", 32'(bus_out), 32'h1234);
        mem_pc_ctrl = 1'b1;
        #1;
        check("bus_prio", 32'(bus_out), 32'h0042);
        mem_pc_ctrl  = 1'b0;
        s_mem_to_bus = 1'b0;

        // Reset in the cycle after a jump
        reg_addr = 16'h0030;
        PCe      = 1'b1;
        npc_ctrl = 1'b1;
        tick();
        check("mid_jmp_pc", 32'(pc), 32'h0030);
        reset = 1'b1;
        i_en  = 1'b1;
        tick();
        reset    = 1'b0;
        i_en     = 1'b0;
        npc_ctrl = 1'b0;
        PCe      = 1'b0;
        check("mid_rst_pc", 32'(pc), 32'h0000);
        check("mid_rst_ir", 32'(ir), 32'h0000);
        WE          = 1'b1;
        mem_pc_ctrl = 1'b1;
        #1;
        check("mid_rst_daddr", 32'(mem_bus.mem_addr), 32'h0000);
        check("mid_rst_link", 32'(bus_out), 32'h0000);
        WE          = 1'b0;
        mem_pc_ctrl = 1'b0;
        PCe         = 1'b1;
        tick();
        check("mid_rst_inc", 32'(pc), 32'h0001);
        PCe = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
